// File: rtl/ball_datapath_pkg.sv
// Shared constants, FSM state encoding and direction encoding for the pong ball datapath.
package ball_datapath_pkg;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;
  localparam int unsigned DEF_TICK_DIV = 833333;
  localparam int unsigned DEF_BALL_X0  = 80;
  localparam int unsigned DEF_BALL_Y0  = 60;
  localparam int unsigned DEF_PADDLE_Y = 112;
  localparam int unsigned DEF_PADDLE_W = 16;
  localparam int unsigned DEF_SCORE_W  = 8;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned POS_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_MISS   = 2'd3
  } state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

endpackage

// File: rtl/ball_datapath_if.sv
// Control-side inputs and draw/display-side outputs of the ball datapath.
interface ball_datapath_if
  import ball_datapath_pkg::*;
#(
  parameter int unsigned SCORE_W = DEF_SCORE_W
);
  logic               move_ball;
  logic               reset_movement;
  logic               reset_co;
  logic [X_W-1:0]     paddle_x;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic [SCORE_W-1:0] score;
  logic               hit;
  logic               miss;
  logic               step;

  modport master (
    output move_ball, reset_movement, reset_co, paddle_x,
    input  ball_x, ball_y, score, hit, miss, step
  );

  modport slave (
    input  move_ball, reset_movement, reset_co, paddle_x,
    output ball_x, ball_y, score, hit, miss, step
  );
endinterface

// File: rtl/ball_datapath_tick_divider.sv
// Frame-tick counter: counts enabled cycles modulo DIV, sync clear, combinational terminal count.
module ball_datapath_tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = (DIV <= 2) ? 1 : $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == CNT_W'(DIV - 1));
  assign tc_c_o = en_i && !clr_i && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ball_datapath.sv
// Ball movement FSM with wall/paddle bounce, saturating score and hit/miss/step strobes.
module ball_datapath
  import ball_datapath_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned BALL_X0  = DEF_BALL_X0,
  parameter int unsigned BALL_Y0  = DEF_BALL_Y0,
  parameter int unsigned PADDLE_Y = DEF_PADDLE_Y,
  parameter int unsigned PADDLE_W = DEF_PADDLE_W,
  parameter int unsigned SCORE_W  = DEF_SCORE_W
) (
  input  logic           clk,
  input  logic           reset,
  ball_datapath_if.slave dp_io
);

  state_e             state_q;
  dir_e               dx_q, dx_d;
  dir_e               dy_q, dy_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [SCORE_W-1:0] score_q;
  logic               hit_q, miss_q, step_q;
  logic               hit_d, miss_d;
  logic               tick_en, tick_clr, tick_tc;
  logic               score_inc;
  logic [POS_W-1:0]   x_ext, y_ext, px_ext;

  ball_datapath_tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .tc_c_o (tick_tc)
  );

  assign tick_en  = (state_q == ST_RUN) && dp_io.move_ball;
  assign tick_clr = !dp_io.reset_movement || (state_q != ST_RUN);

  // Bounce decisions on the pre-move position; compares run one bit wider so px+W cannot wrap.
  always_comb begin
    dx_d   = dx_q;
    dy_d   = dy_q;
    hit_d  = 1'b0;
    x_ext  = {1'b0, x_q};
    y_ext  = {2'b00, y_q};
    px_ext = {1'b0, dp_io.paddle_x};

    if (((x_q == '0) && (dx_q == DIR_NEG)) ||
        ((x_ext == POS_W'(SCREEN_W - 1)) && (dx_q == DIR_POS))) begin
      dx_d = (dx_q == DIR_POS) ? DIR_NEG : DIR_POS;
    end
    if ((y_q == '0) && (dy_q == DIR_NEG)) begin
      dy_d = DIR_POS;
    end
    if ((dy_q == DIR_POS) && ((y_ext + POS_W'(1)) == POS_W'(PADDLE_Y)) &&
        (px_ext <= x_ext) && (x_ext < (px_ext + POS_W'(PADDLE_W)))) begin
      dy_d  = DIR_NEG;
      hit_d = 1'b1;
    end

    x_d    = (dx_d == DIR_POS) ? x_q + X_W'(1) : x_q - X_W'(1);
    y_d    = (dy_d == DIR_POS) ? y_q + Y_W'(1) : y_q - Y_W'(1);
    miss_d = (y_d == Y_W'(SCREEN_H - 1));
  end

  assign score_inc = dp_io.reset_movement && (state_q == ST_UPDATE) && hit_d && !(&score_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= X_W'(BALL_X0);
      y_q     <= Y_W'(BALL_Y0);
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      step_q <= 1'b0;

      if (!dp_io.reset_movement) begin
        state_q <= ST_IDLE;
        x_q     <= X_W'(BALL_X0);
        y_q     <= Y_W'(BALL_Y0);
        dx_q    <= DIR_POS;
        dy_q    <= DIR_NEG;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (dp_io.move_ball) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (tick_tc) state_q <= ST_UPDATE;
          end
          ST_UPDATE: begin
            x_q    <= x_d;
            y_q    <= y_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            step_q <= 1'b1;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            state_q <= miss_d ? ST_MISS : ST_RUN;
          end
          ST_MISS: begin
            state_q <= ST_MISS;
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      // Score clear wins over a same-cycle paddle hit.
      if (!dp_io.reset_co) begin
        score_q <= '0;
      end else if (score_inc) begin
        score_q <= score_q + SCORE_W'(1);
      end
    end
  end

  assign dp_io.ball_x = x_q;
  assign dp_io.ball_y = y_q;
  assign dp_io.score  = score_q;
  assign dp_io.hit    = hit_q;
  assign dp_io.miss   = miss_q;
  assign dp_io.step   = step_q;

endmodule

// File: tb/tb_ball_datapath.sv
// Randomized bench for ball_datapath against a cycle-level integer model of the game rules.
module tb_ball_datapath;

  localparam int TD   = 4;
  localparam int NCYC = 40000;
  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int PY   = 112;
  localparam int PW   = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_UPD  = 2;
  localparam int PH_MISS = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_datapath_if #(.SCORE_W(8)) bus ();
  ball_datapath_if #(.SCORE_W(2)) bus_s ();

  assign bus_s.move_ball      = bus.move_ball;
  assign bus_s.reset_movement = bus.reset_movement;
  assign bus_s.reset_co       = bus.reset_co;
  assign bus_s.paddle_x       = bus.paddle_x;

  ball_datapath #(.TICK_DIV(TD), .SCORE_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .dp_io (bus.slave)
  );

  ball_datapath #(.TICK_DIV(TD), .SCORE_W(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .dp_io (bus_s.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int mx, my, mdx, mdy, ms8, ms2, mph, mcnt;
  bit e_hit, e_miss, e_step;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset_move();
    mx = 80; my = 60; mdx = 1; mdy = -1; mph = PH_IDLE; mcnt = 0;
  endtask

  task automatic model_full_reset();
    model_reset_move();
    ms8 = 0; ms2 = 0;
    e_hit = 0; e_miss = 0; e_step = 0;
  endtask

  function automatic bit paddle_hits(input int px);
    return (mdy > 0) && (my + 1 == PY) && (px <= mx) && (mx < px + PW);
  endfunction

  task automatic model_step(input bit mb, input bit rm, input bit rco, input int px);
    int ndx, ndy;
    bit h;
    h = 0; e_hit = 0; e_miss = 0; e_step = 0;
    if (!rm) begin
      model_reset_move();
    end else begin
      case (mph)
        PH_IDLE: if (mb) begin mph = PH_RUN; mcnt = 0; end
        PH_RUN: if (mb) begin
          if (mcnt == TD - 1) begin mph = PH_UPD; mcnt = 0; end
          else mcnt++;
        end
        PH_UPD: begin
          ndx = mdx; ndy = mdy;
          if ((mx == 0 && mdx < 0) || (mx == SW - 1 && mdx > 0)) ndx = -mdx;
          if (my == 0 && mdy < 0) ndy = 1;
          if (paddle_hits(px)) begin ndy = -1; h = 1; end
          mdx = ndx; mdy = ndy;
          mx += mdx; my += mdy;
          e_step = 1; e_hit = h;
          if (my == SH - 1) begin e_miss = 1; mph = PH_MISS; end
          else mph = PH_RUN;
        end
        default: ;
      endcase
    end
    if (!rco) begin
      ms8 = 0; ms2 = 0;
    end else if (h) begin
      if (ms8 < 255) ms8++;
      if (ms2 < 3) ms2++;
    end
  endtask

  task automatic compare_all(input string pfx);
    check_eq({pfx, "ball_x"}, 32'(bus.ball_x), 32'(mx));
    check_eq({pfx, "ball_y"}, 32'(bus.ball_y), 32'(my));
    check_eq({pfx, "score"},  32'(bus.score), 32'(ms8));
    check_eq({pfx, "hit"},    32'(bus.hit), 32'(e_hit));
    check_eq({pfx, "miss"},   32'(bus.miss), 32'(e_miss));
    check_eq({pfx, "step"},   32'(bus.step), 32'(e_step));
    check_eq({pfx, "score_w2"}, 32'(bus_s.score), 32'(ms2));
  endtask

  initial begin
    int  pause_left, miss_wait, first_step_cyc, px, n_hit, n_miss, prev_s_score;
    bit  mb, rm, rco, want_miss, clr_now, clr_done, sat_seen;

    pause_left = 0; miss_wait = 0; first_step_cyc = 0; n_hit = 0; n_miss = 0;
    want_miss = 0; clr_done = 0; sat_seen = 0;

    reset = 1'b1;
    bus.move_ball = 1'b1; bus.reset_movement = 1'b1; bus.reset_co = 1'b1; bus.paddle_x = 8'd70;
    model_full_reset();
    repeat (2) @(posedge clk);
    #1 compare_all("rst_");
    @(negedge clk);
    reset = 1'b0;

    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      if (cyc == 20000) begin
        // Asynchronous reset mid-run, asserted away from the clock edge.
        reset = 1'b1;
        #1;
        model_full_reset();
        compare_all("arst_");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        miss_wait = 0;
      end

      // move_ball with random pause bursts after the initial latency window
      if (pause_left > 0) begin
        mb = 0; pause_left--;
      end else if (cyc > 20 && $urandom_range(0, 99) < 3) begin
        pause_left = $urandom_range(1, 12); mb = 0;
      end else begin
        mb = 1;
      end

      rm = 1;
      if (mph == PH_MISS) begin
        miss_wait++;
        if (miss_wait >= 100) begin rm = 0; miss_wait = 0; end
      end
      if (cyc > 20 && $urandom_range(0, 7999) == 0) rm = 0;

      if (want_miss) px = (mx < 72) ? 144 : 0;
      else if ($urandom_range(0, 7) == 0) px = $urandom_range(0, 144);
      else begin
        px = mx - $urandom_range(0, 15);
        if (px < 0) px = 0;
        if (px > 144) px = 144;
      end

      rco = 1; clr_now = 0;
      if (!clr_done && sat_seen && ms2 == 3 && rm && mph == PH_UPD && paddle_hits(px)) begin
        rco = 0; clr_now = 1; clr_done = 1;
      end else if (clr_done && $urandom_range(0, 4999) == 0) begin
        rco = 0;
      end

      bus.move_ball      = mb;
      bus.reset_movement = rm;
      bus.reset_co       = rco;
      bus.paddle_x       = 8'(px);
      prev_s_score       = int'(bus_s.score);

      model_step(mb, rm, rco, px);
      if (e_step && my == 30) want_miss = ($urandom_range(0, 3) == 0);

      @(posedge clk);
      #1;
      compare_all("");

      if (bus.hit) n_hit++;
      if (bus.miss) n_miss++;
      if (bus_s.hit && rco && prev_s_score == 3 && bus_s.score == 2'd3) sat_seen = 1;
      if (clr_now) check_eq("clr_on_hit", 32'(bus.score), 32'd0);
      if (bus.step && first_step_cyc == 0) begin
        first_step_cyc = cyc;
        check_eq("first_step_lat", 32'(cyc), 32'd6);
        check_eq("first_step_x", 32'(bus.ball_x), 32'd81);
        check_eq("first_step_y", 32'(bus.ball_y), 32'd59);
      end
      @(negedge clk);
    end

    check_eq("hits_seen", 32'(n_hit >= 5), 32'd1);
    check_eq("miss_seen", 32'(n_miss >= 1), 32'd1);
    check_eq("sat_seen", 32'(sat_seen), 32'd1);
    check_eq("clr_hit_seen", 32'(clr_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
